// File: rtl/apb_cmd_pkg.sv
// Shared types and constants for the APB command master.
package apb_cmd_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/apb_cmd_master_if.sv
// Command/response handshake plus APB master bus for apb_cmd_master.
// The master modport is the DUT view; the slave modport is the environment view.
interface apb_cmd_master_if;
    import apb_cmd_pkg::*;

    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;
    logic              m_apb_psel_o;
    logic              m_apb_penable_o;
    logic [ADDR_W-1:0] m_apb_paddr_o;
    logic              m_apb_pwrite_o;
    logic [DATA_W-1:0] m_apb_pwdata_o;
    logic [DATA_W-1:0] m_apb_prdata_i;
    logic              m_apb_pready_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
               m_apb_prdata_i, m_apb_pready_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               m_apb_psel_o, m_apb_penable_o, m_apb_paddr_o, m_apb_pwrite_o, m_apb_pwdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, rsp_ready_i,
               m_apb_prdata_i, m_apb_pready_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               m_apb_psel_o, m_apb_penable_o, m_apb_paddr_o, m_apb_pwrite_o, m_apb_pwdata_o
    );

endinterface

// File: rtl/apb_cmd_master.sv
// APB command master: turns one command into one APB transfer and one response.
// Optional ACCESS-phase timeout enabled by macro APB_CMD_MASTER_TIMEOUT_EN;
// without it ACCESS waits indefinitely and rsp_err_o is constant 0.
module apb_cmd_master
    import apb_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    apb_cmd_master_if.master     bus
);

    state_t            state;
    logic              cmd_ready;
    logic              psel;
    logic              penable;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic [7:0]        wait_cnt;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic rsp_err;
`else
    // Parameter is accepted for a uniform instantiation but drives nothing here.
    logic [7:0] timeout_unused;
    assign timeout_unused = 8'(TIMEOUT_CYCLES);
`endif

    // Transfer FSM; every bus-facing output is registered here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            wait_cnt  <= '0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid_i) begin
                        paddr     <= bus.cmd_addr_i;
                        pwrite    <= bus.cmd_write_i;
                        pwdata    <= bus.cmd_wdata_i;
                        psel      <= 1'b1;
                        cmd_ready <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    // pready is deliberately ignored in the setup cycle
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (bus.m_apb_pready_i) begin
                        rsp_rdata <= pwrite ? '0 : bus.m_apb_prdata_i;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
                        rsp_err   <= 1'b0;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        // pready has priority over timeout on the same cycle
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
`endif
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready_o     = cmd_ready;
    assign bus.m_apb_psel_o    = psel;
    assign bus.m_apb_penable_o = penable;
    assign bus.m_apb_paddr_o   = paddr;
    assign bus.m_apb_pwrite_o  = pwrite;
    assign bus.m_apb_pwdata_o  = pwdata;
    assign bus.rsp_valid_o     = rsp_valid;
    assign bus.rsp_rdata_o     = rsp_rdata;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    assign bus.rsp_err_o       = rsp_err;
`else
    assign bus.rsp_err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// Testbench for apb_cmd_master (build with or without APB_CMD_MASTER_TIMEOUT_EN).
module tb_apb_cmd_master;

    localparam int TO = 16;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    apb_cmd_master_if bus ();

    apb_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    typedef struct {
        int         hs_cyc;
        int         setup_cyc;
        int         setup_count;
        int         access_cycles;
        int         resp_cycles;
        int         proto_bad;
        bit         ready_at_start;
        bit         got_resp;
        logic [7:0] rdata;
        logic       err;
    } obs_t;

    // Reference model: outcome of one command from the documented rules.
    function automatic void model(input bit w, input int nwait, input logic [7:0] rd,
                                  output int acc, output logic [7:0] rdata, output logic err);
        bit to;
        to    = TO_EN && (nwait >= TO);
        acc   = to ? TO : nwait + 1;
        rdata = (w || to) ? 8'h00 : rd;
        err   = to;
    endfunction

    // Issue one command, play the APB slave (pready on access cycle nwait),
    // hold the response for 'hold' extra cycles, and record what was seen.
    task automatic drive_cmd(input bit w, input logic [7:0] a, input logic [7:0] d,
                             input int nwait, input logic [7:0] rd, input int hold,
                             output obs_t o);
        int n;
        o = '{hs_cyc: cyc, setup_cyc: -1, setup_count: 0, access_cycles: 0, resp_cycles: 0,
              proto_bad: 0, ready_at_start: bus.cmd_ready_o, got_resp: 1'b0,
              rdata: 8'h00, err: 1'b0};
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = w;
        bus.cmd_addr_i  = a;
        bus.cmd_wdata_i = d;
        bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        n = 0;
        while (n < 2000) begin
            if (bus.m_apb_psel_o === 1'b1) begin
                if (o.setup_cyc < 0) o.setup_cyc = cyc;
                if (bus.m_apb_paddr_o !== a || bus.m_apb_pwrite_o !== w ||
                    bus.m_apb_pwdata_o !== d || bus.cmd_ready_o !== 1'b0 ||
                    bus.rsp_valid_o !== 1'b0)
                    o.proto_bad++;
                if (bus.m_apb_penable_o !== 1'b1) begin
                    o.setup_count++;
                    bus.m_apb_pready_i = 1'($urandom);
                    bus.m_apb_prdata_i = 8'($urandom);
                end else begin
                    bus.m_apb_pready_i = (o.access_cycles == nwait);
                    bus.m_apb_prdata_i = (o.access_cycles == nwait) ? rd : 8'($urandom);
                    o.access_cycles++;
                end
            end else if (o.setup_cyc >= 0 || n > 2) begin
                break;
            end
            n++;
            @(negedge clk);
        end
        bus.m_apb_pready_i = 1'b0;
        if (bus.rsp_valid_o !== 1'b1) return;
        o.got_resp = 1'b1;
        o.rdata = bus.rsp_rdata_o;
        o.err   = bus.rsp_err_o;
        for (int j = 0; j <= hold; j++) begin
            if (bus.rsp_valid_o === 1'b1) o.resp_cycles++;
            if (bus.rsp_rdata_o !== o.rdata || bus.rsp_err_o !== o.err ||
                bus.cmd_ready_o !== 1'b0 || bus.m_apb_psel_o !== 1'b0)
                o.proto_bad++;
            bus.rsp_ready_i = (j == hold);
            bus.cmd_valid_i = (hold > 0);
            bus.cmd_write_i = 1'($urandom);
            bus.cmd_addr_i  = 8'($urandom);
            @(negedge clk);
        end
        if (bus.rsp_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1 || bus.m_apb_psel_o !== 1'b0)
            o.proto_bad++;
        bus.rsp_ready_i = 1'b0;
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.m_apb_psel_o !== 1'b0) begin bad++; $display("FAIL reset_psel: got %b want 0", bus.m_apb_psel_o); end
        total++; if (bus.m_apb_penable_o !== 1'b0) begin bad++; $display("FAIL reset_penable: got %b want 0", bus.m_apb_penable_o); end
        total++; if (bus.m_apb_paddr_o !== 8'h00) begin bad++; $display("FAIL reset_paddr: got %h want 00", bus.m_apb_paddr_o); end
        total++; if (bus.m_apb_pwrite_o !== 1'b0) begin bad++; $display("FAIL reset_pwrite: got %b want 0", bus.m_apb_pwrite_o); end
        total++; if (bus.m_apb_pwdata_o !== 8'h00) begin bad++; $display("FAIL reset_pwdata: got %h want 00", bus.m_apb_pwdata_o); end
        total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid_o); end
        total++; if (bus.rsp_rdata_o !== 8'h00) begin bad++; $display("FAIL reset_rsp_rdata: got %h want 00", bus.rsp_rdata_o); end
        total++; if (bus.rsp_err_o !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err_o); end
        bus.cmd_valid_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.cmd_ready_o !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready_o); end
    endtask

    task automatic test_write_basic();
        obs_t o;
        drive_cmd(1'b1, 8'h03, 8'h83, 0, 8'($urandom), 0, o);
        total++; if (o.ready_at_start !== 1'b1) begin bad++; $display("FAIL wr_ready: got %b want 1", o.ready_at_start); end
        total++; if (o.setup_cyc - o.hs_cyc !== 1) begin bad++; $display("FAIL wr_psel_delay: got %0d want 1", o.setup_cyc - o.hs_cyc); end
        total++; if (o.setup_count !== 1) begin bad++; $display("FAIL wr_setup_len: got %0d want 1", o.setup_count); end
        total++; if (o.access_cycles !== 1) begin bad++; $display("FAIL wr_access_len: got %0d want 1", o.access_cycles); end
        total++; if (o.got_resp !== 1'b1) begin bad++; $display("FAIL wr_resp: got %b want 1", o.got_resp); end
        total++; if (o.rdata !== 8'h00) begin bad++; $display("FAIL wr_rdata: got %h want 00", o.rdata); end
        total++; if (o.err !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", o.err); end
        total++; if (o.proto_bad !== 0) begin bad++; $display("FAIL wr_protocol: got %0d want 0", o.proto_bad); end
    endtask

    task automatic test_read_wait();
        obs_t o;
        drive_cmd(1'b0, 8'h00, 8'($urandom), 3, 8'h5A, 0, o);
        total++; if (o.access_cycles !== 4) begin bad++; $display("FAIL rd_access_len: got %0d want 4", o.access_cycles); end
        total++; if (o.rdata !== 8'h5A) begin bad++; $display("FAIL rd_rdata: got %h want 5a", o.rdata); end
        total++; if (o.err !== 1'b0) begin bad++; $display("FAIL rd_err: got %b want 0", o.err); end
        total++; if (o.proto_bad !== 0) begin bad++; $display("FAIL rd_protocol: got %0d want 0", o.proto_bad); end
    endtask

    task automatic test_resp_hold();
        obs_t o;
        logic [7:0] rd;
        rd = 8'($urandom);
        drive_cmd(1'b0, 8'($urandom), 8'($urandom), 1, rd, 5, o);
        total++; if (o.resp_cycles !== 6) begin bad++; $display("FAIL hold_resp_len: got %0d want 6", o.resp_cycles); end
        total++; if (o.rdata !== rd) begin bad++; $display("FAIL hold_rdata: got %h want %h", o.rdata, rd); end
        total++; if (o.proto_bad !== 0) begin bad++; $display("FAIL hold_protocol: got %0d want 0", o.proto_bad); end
    endtask

    task automatic test_timeout();
        obs_t o;
        int acc;
        logic [7:0] erd;
        logic eerr;
        int nw [3] = '{TO - 1, TO, 300};
        for (int k = 0; k < 3; k++) begin
            drive_cmd(1'b0, 8'($urandom), 8'($urandom), nw[k], 8'hC3, 0, o);
            model(1'b0, nw[k], 8'hC3, acc, erd, eerr);
            total++; if (o.access_cycles !== acc) begin bad++; $display("FAIL to_access_len[%0d]: got %0d want %0d", nw[k], o.access_cycles, acc); end
            total++; if (o.err !== eerr) begin bad++; $display("FAIL to_err[%0d]: got %b want %b", nw[k], o.err, eerr); end
            total++; if (o.rdata !== erd) begin bad++; $display("FAIL to_rdata[%0d]: got %h want %h", nw[k], o.rdata, erd); end
            total++; if (o.proto_bad !== 0) begin bad++; $display("FAIL to_protocol[%0d]: got %0d want 0", nw[k], o.proto_bad); end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b0;
        bus.cmd_addr_i  = 8'h44;
        bus.m_apb_pready_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.cmd_valid_i = 1'b0;
        @(negedge clk);
        total++; if (bus.m_apb_penable_o !== 1'b1) begin bad++; $display("FAIL rm_in_access: got %b want 1", bus.m_apb_penable_o); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus.m_apb_psel_o !== 1'b0) begin bad++; $display("FAIL rm_psel: got %b want 0", bus.m_apb_psel_o); end
        total++; if (bus.m_apb_penable_o !== 1'b0) begin bad++; $display("FAIL rm_penable: got %b want 0", bus.m_apb_penable_o); end
        total++; if (bus.rsp_valid_o !== 1'b0) begin bad++; $display("FAIL rm_rsp_valid: got %b want 0", bus.rsp_valid_o); end
        total++; if (bus.cmd_ready_o !== 1'b1) begin bad++; $display("FAIL rm_cmd_ready: got %b want 1", bus.cmd_ready_o); end
        total++; if (bus.m_apb_paddr_o !== 8'h00) begin bad++; $display("FAIL rm_paddr: got %h want 00", bus.m_apb_paddr_o); end
        seen = 0;
        bus.m_apb_pready_i = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid_o !== 1'b0 || bus.m_apb_psel_o !== 1'b0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rm_no_response: got %0d active cycles want 0", seen); end
        bus.m_apb_pready_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        logic [7:0] rd;
        rd = 8'($urandom);
        bus.rsp_ready_i = 1'b1;
        drive_cmd(1'b1, 8'h01, 8'h07, 0, 8'($urandom), 0, o1);
        drive_cmd(1'b0, 8'h05, 8'($urandom), 0, rd, 0, o2);
        total++; if (o2.setup_cyc - o1.setup_cyc !== 4) begin bad++; $display("FAIL b2b_spacing: got %0d want 4", o2.setup_cyc - o1.setup_cyc); end
        total++; if (o1.rdata !== 8'h00) begin bad++; $display("FAIL b2b_wr_rdata: got %h want 00", o1.rdata); end
        total++; if (o2.rdata !== rd) begin bad++; $display("FAIL b2b_rd_rdata: got %h want %h", o2.rdata, rd); end
        total++; if (o1.proto_bad + o2.proto_bad !== 0) begin bad++; $display("FAIL b2b_protocol: got %0d want 0", o1.proto_bad + o2.proto_bad); end
    endtask

    task automatic test_random();
        obs_t o;
        bit w;
        logic [7:0] a, d, rd, erd;
        logic eerr;
        int nwait, hold, acc;
        for (int t = 0; t < 24; t++) begin
            w = 1'($urandom);
            a = 8'($urandom);
            d = 8'($urandom);
            rd = 8'($urandom);
            nwait = $urandom_range(0, 20);
            hold = $urandom_range(0, 3);
            model(w, nwait, rd, acc, erd, eerr);
            drive_cmd(w, a, d, nwait, rd, hold, o);
            total++; if (o.got_resp !== 1'b1 || o.resp_cycles !== hold + 1) begin bad++; $display("FAIL rnd_resp[%0d]: got %0d cycles want %0d", t, o.resp_cycles, hold + 1); end
            total++; if (o.access_cycles !== acc || o.setup_count !== 1) begin bad++; $display("FAIL rnd_phases[%0d]: got access %0d setup %0d want %0d 1", t, o.access_cycles, o.setup_count, acc); end
            total++; if (o.rdata !== erd || o.err !== eerr) begin bad++; $display("FAIL rnd_data[%0d]: got %h/%b want %h/%b", t, o.rdata, o.err, erd, eerr); end
            total++; if (o.proto_bad !== 0) begin bad++; $display("FAIL rnd_protocol[%0d]: got %0d want 0", t, o.proto_bad); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.cmd_valid_i    = 1'b0;
        bus.cmd_write_i    = 1'b0;
        bus.cmd_addr_i     = 8'h00;
        bus.cmd_wdata_i    = 8'h00;
        bus.rsp_ready_i    = 1'b0;
        bus.m_apb_prdata_i = 8'h00;
        bus.m_apb_pready_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_basic();
        test_read_wait();
        test_resp_hold();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk_i sampled on rising edge; rst_i synchronous, active-high.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, max ACCESS-phase cycles before abort (range 1..255).
REQ-003 Ports, clock and reset first:
- clk_i  in  1  reference clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  command request valid
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  8  register address
- cmd_wdata_i  in  8  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when high with rsp_valid_o
- rsp_rdata_o  out  8  read data; 0x00 for writes and aborted transfers
- rsp_err_o  out  1  transfer aborted by timeout
- m_apb_psel_o  out  1  APB select
- m_apb_penable_o  out  1  APB enable
- m_apb_paddr_o  out  8  APB address
- m_apb_pwrite_o  out  1  APB direction
- m_apb_pwdata_o  out  8  APB write data
- m_apb_prdata_i  in  8  APB read data
- m_apb_pready_i  in  1  APB ready

Function
REQ-004 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-005 In IDLE: cmd_ready_o = 1. In all other states: cmd_ready_o = 0.
REQ-006 IDLE with cmd_valid_i = 1: register write/addr/wdata into the APB output registers and go to SETUP.
REQ-007 In SETUP: psel = 1 and penable = 0 for exactly one cycle, then go to ACCESS. m_apb_pready_i is ignored in SETUP.
REQ-008 In ACCESS: psel = 1 and penable = 1. Stay in ACCESS while pready = 0.
REQ-009 When pready = 1 in ACCESS:
- capture prdata into rsp_rdata_o for reads; set rsp_rdata_o = 0x00 for writes;
- set rsp_err_o = 0;
- deassert psel and penable at the same edge;
- go to RESP.
REQ-010 paddr/pwrite/pwdata SHALL stay stable from SETUP through the last ACCESS cycle, and hold their value while idle.
REQ-011 In RESP: rsp_valid_o = 1, with rsp_rdata_o and rsp_err_o stable until rsp_ready_i = 1, then go to IDLE. rsp_ready_i has no effect outside RESP.
REQ-012 Minimum command-to-command throughput is 4 cycles (IDLE, SETUP, ACCESS, RESP) with zero wait states and rsp_ready_i tied high.
REQ-013 Wait counter: 8-bit; cleared on entry to SETUP; increments each ACCESS cycle with pready = 0; saturates and does not wrap.

Reset
REQ-014 When rst_i = 1 at a clock edge, regardless of current state:
- state goes to IDLE;
- outputs become: psel = 0, penable = 0, paddr = 0x00, pwrite = 0, pwdata = 0x00, rsp_valid_o = 0, rsp_rdata_o = 0x00, rsp_err_o = 0, wait counter = 0.
REQ-015 Reset during SETUP or ACCESS SHALL abort the transfer with no response. cmd_ready_o = 1 in the first cycle after rst_i falls.

Configuration
REQ-016 Macro APB_CMD_MASTER_TIMEOUT_EN.
- Defined: in ACCESS with pready = 0 and wait counter = TIMEOUT_CYCLES-1, deassert psel/penable, set rsp_err_o = 1 and rsp_rdata_o = 0x00, go to RESP. pready arriving on that same cycle wins: normal completion, rsp_err_o = 0.
- Undefined: ACCESS waits indefinitely, rsp_err_o is tied 0, and the timeout comparison logic is not built.

Structure
REQ-017 Shared package apb_cmd_pkg SHALL hold:
- the state enum (IDLE, SETUP, ACCESS, RESP);
- ADDR_W = 8, DATA_W = 8;
- default TIMEOUT_CYCLES.
REQ-018 Single module with no sub-module. The wait counter is inline logic.

Verification
REQ-019 Write addr 0x03, data 0x83, pready held high:
- psel rises 1 cycle after the handshake; penable 1 cycle later;
- rsp_valid_o 1 cycle later with rsp_err_o = 0 and rsp_rdata_o = 0x00.
REQ-020 Read addr 0x00 with 3 wait states, prdata = 0x5A on the ready cycle: ACCESS lasts 4 cycles; rsp_rdata_o = 0x5A.
REQ-021 Macro defined, TIMEOUT_CYCLES = 16, pready held low: after 16 ACCESS cycles, psel drops and rsp_err_o = 1 with rsp_rdata_o = 0x00. Same test with macro undefined: psel stays high for at least 300 cycles.
REQ-022 rsp_ready_i held low for 5 cycles in RESP: rsp outputs stay stable, cmd_ready_o = 0, and a waiting cmd_valid_i is not accepted until the cycle after release.
REQ-023 rst_i pulsed during ACCESS of a read: next cycle psel = penable = rsp_valid_o = 0 and cmd_ready_o = 1, and no response is issued.
REQ-024 Back-to-back commands (write 0x01/0x07, then read 0x05), zero wait states, rsp_ready_i high: second psel rises exactly 4 cycles after the first.
